fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch-side controller for the instruction_decoder. Reads 16-bit instruction words over a
//  req/ack memory port and assembles one- or two-word instructions into i_ir1/i_ir2.
//  Presents each instruction to the decoder with a valid flag and holds it until execute
//  completes. Owns the program counter: sequential advance, jumps, and a sticky fault on
//  decode error.
// PARAMETERS
//  RESET_PC        16'h0000  PC value loaded by reset
//  LONG_BIT        15        IR1 bit index; 1 = two-word instruction (IR2 fetched), 0 = one word
//  TIMEOUT_CYCLES  16        max cycles waiting for i_mem_ack (only with FETCH_TIMEOUT_EN)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_rst          in   1   asynchronous active-high reset
//  o_mem_req      out  1   memory read request, held until acked
//  o_mem_addr     out  16  word address of request
//  i_mem_rdata    in   16  read data, valid when i_mem_ack=1
//  i_mem_ack      in   1   one-cycle read completion
//  o_ir1          out  16  first instruction word, to decoder i_ir1
//  o_ir2          out  16  second word (0 for one-word instructions), to decoder i_ir2
//  o_ir_valid     out  1   o_ir1/o_ir2 hold a complete instruction
//  i_dec_err      in   1   decoder o_err
//  i_exec_done    in   1   execute stage finished current instruction
//  i_jump         in   1   with i_exec_done: next fetch from i_jump_addr
//  i_jump_addr    in   16  jump target
//  o_pc           out  16  address of next word to fetch
//  o_fault        out  1   sticky fault flag
// BEHAVIOUR
//  Reset values: o_mem_req=0, o_mem_addr=0, o_ir1=0, o_ir2=0, o_ir_valid=0,
//   o_pc=RESET_PC, o_fault=0, state=F1. Reset mid-transaction abandons it; late acks ignored.
//  States: F1 (fetch word 1), F2 (fetch word 2), ISSUE, FAULT.
//  F1:    o_mem_req=1, o_mem_addr=o_pc. On ack: o_ir1<=rdata, o_pc<=o_pc+1.
//         rdata[LONG_BIT]=1 -> F2; else o_ir2<=0 -> ISSUE.
//  F2:    o_mem_req=1, o_mem_addr=o_pc. On ack: o_ir2<=rdata, o_pc<=o_pc+1 -> ISSUE.
//  ISSUE: o_mem_req=0, o_ir_valid=1, IR registers frozen.
//   - i_dec_err=1 -> FAULT (wins over i_exec_done in the same cycle).
//   - i_exec_done=1, i_jump=1 -> o_pc<=i_jump_addr, valid<=0 -> F1.
//   - i_exec_done=1, i_jump=0 -> valid<=0 -> F1.
//  FAULT: o_fault=1, o_ir_valid=0, o_mem_req=0. Leaves only via reset.
//  Latency: request asserted in the cycle after entering F1/F2. Minimum issue latency with
//   zero-wait ack: 2 cycles for one word, 3 for two words. Returns to F1 the cycle after
//   exec_done.
//  PC arithmetic: 16-bit modulo; 16'hFFFF+1 = 16'h0000. A two-word instruction at FFFF
//   takes word 2 from 0000.
//  i_mem_ack outside F1/F2 is ignored. i_jump without i_exec_done is ignored.
//   i_exec_done outside ISSUE is ignored.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - Wait counter cleared on entry to F1/F2 and on each ack.
//   - Counter increments every cycle o_mem_req=1 and i_mem_ack=0.
//   - Counter reaching TIMEOUT_CYCLES -> FAULT.
//  FETCH_TIMEOUT_EN undefined: no counter; F1/F2 wait for ack indefinitely.
// TESTING
//  1 Reset, mem returns 16'h0123 at 0000 with 0 wait -> o_ir1=0123, o_ir2=0,
//    valid 2 cycles after reset release, o_pc=0001.
//  2 Word 16'h8000 at 0000, 16'h3000 at 0001 -> o_ir1=8000, o_ir2=3000, o_pc=0002;
//    3-cycle wait states on each ack add exactly 3 cycles per word.
//  3 In ISSUE: exec_done=1, jump=1, jump_addr=16'h0040 -> next o_mem_addr=0040.
//  4 In ISSUE: dec_err=1 and exec_done=1 in the same cycle -> o_fault=1, no further
//    o_mem_req until reset.
//  5 RESET_PC=16'hFFFF, word 16'h8001 at FFFF -> second fetch addr 0000, o_pc=0001.
//  6 Reset while F2 awaits ack, then ack arrives -> ignored; fetch restarts at RESET_PC.
//    With FETCH_TIMEOUT_EN and no ack for 16 cycles -> o_fault=1.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: assembles one- or two-word instructions over a req/ack port
// and holds them for the decoder. Optional FETCH_TIMEOUT_EN faults on a stalled memory.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned LONG_BIT = 15
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic [15:0] o_ir1,
  output logic [15:0] o_ir2,
  output logic        o_ir_valid,
  input  logic        i_dec_err,
  input  logic        i_exec_done,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  output logic [15:0] o_pc,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    ST_F1    = 2'd0,
    ST_F2    = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ir1_q, ir1_d;
  logic [15:0] ir2_q, ir2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        ack_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // An ack only completes a read we actually have outstanding; stale acks after reset drop here.
  assign ack_ok = req_q & i_mem_ack;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    fault_d = fault_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    unique case (state_q)
      ST_F1: begin
        req_d  = 1'b1;
        addr_d = pc_q;
        if (ack_ok) begin
          ir1_d = i_mem_rdata;
          pc_d  = pc_q + 16'd1;
`ifdef FETCH_TIMEOUT_EN
          wait_d = '0;
`endif
          if (i_mem_rdata[LONG_BIT]) begin
            state_d = ST_F2;
            addr_d  = pc_q + 16'd1;
          end else begin
            ir2_d   = 16'h0000;
            req_d   = 1'b0;
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (req_q) begin
          if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
`endif
      end
      ST_F2: begin
        req_d  = 1'b1;
        addr_d = pc_q;
        if (ack_ok) begin
          ir2_d   = i_mem_rdata;
          pc_d    = pc_q + 16'd1;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (req_q) begin
          if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
`endif
      end
      ST_ISSUE: begin
        req_d = 1'b0;
        // A decode error outranks completion: the faulting instruction must not retire.
        if (i_dec_err) begin
          valid_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else if (i_exec_done) begin
          valid_d = 1'b0;
          if (i_jump) pc_d = i_jump_addr;
          state_d = ST_F1;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      ST_FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same old values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_F1;
      req_q   <= 1'b0;
      addr_q  <= 16'h0000;
      ir1_q   <= 16'h0000;
      ir2_q   <= 16'h0000;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign o_mem_req  = req_q;
  assign o_mem_addr = addr_q;
  assign o_ir1      = ir1_q;
  assign o_ir2      = ir2_q;
  assign o_ir_valid = valid_q;
  assign o_pc       = pc_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs with a wait-state memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] o_ir1, o_ir2, o_pc;
  logic        o_ir_valid, o_fault;
  logic        dec_err = 1'b0;
  logic        exec_done = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_addr = 16'h0000;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [logic [15:0]];
  int          mem_wait = 0;
  int          wcnt = 0;
  bit          block = 1'b0;
  bit          late_pulse = 1'b0;

  logic [47:0] sb [$];
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_ir1       (o_ir1),
    .o_ir2       (o_ir2),
    .o_ir_valid  (o_ir_valid),
    .i_dec_err   (dec_err),
    .i_exec_done (exec_done),
    .i_jump      (jump),
    .i_jump_addr (jump_addr),
    .o_pc        (o_pc),
    .o_fault     (o_fault)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Memory: acks after mem_wait idle cycles of an asserted request; driven on the falling edge.
  always @(negedge clk) begin
    if (late_pulse) begin
      mem_ack    = 1'b1;
      mem_rdata  = 16'hFFFF;
      late_pulse = 1'b0;
    end else if (rst || !o_mem_req || block) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (mem_ack) wcnt = 0;
      if (wcnt == mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = rd(o_mem_addr);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: each new instruction presentation is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_ir_valid && !prev_valid) begin
        if (sb.size() == 0) check("sb_unexpected", {o_ir1, o_ir2, o_pc}, 48'h0);
        else check("sb_instr", {o_ir1, o_ir2, o_pc}, sb.pop_front());
      end
      prev_valid = o_ir_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!o_ir_valid && cyc < 100);
    check(name, {47'h0, o_ir_valid}, 48'h1);
  endtask

  task automatic exec(input logic j, input logic [15:0] a);
    exec_done = 1'b1;
    jump      = j;
    jump_addr = a;
    @(posedge clk); #1;
    exec_done = 1'b0;
    jump      = 1'b0;
  endtask

  int   lat;
  logic any_req;

  initial begin
    mem[16'h0000] = 16'h0123;
    mem[16'h0001] = 16'h8000;
    mem[16'h0002] = 16'h3000;
    mem[16'h0040] = 16'h0055;
    mem[16'hFFFF] = 16'h8001;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {47'h0, o_mem_req}, 48'h0);
    check("rst_addr",  {32'h0, o_mem_addr}, 48'h0);
    check("rst_ir",    {16'h0, o_ir1, o_ir2}, 48'h0);
    check("rst_valid", {47'h0, o_ir_valid}, 48'h0);
    check("rst_pc",    {32'h0, o_pc}, 48'h0);
    check("rst_fault", {47'h0, o_fault}, 48'h0);

    // One-word instruction, zero wait: valid two edges after release
    sb.push_back({16'h0123, 16'h0000, 16'h0001});
    rst = 1'b0;
    wait_valid("t1_valid", lat);
    check("t1_latency", 48'(lat), 48'd2);

    // Two-word instruction, zero wait
    sb.push_back({16'h8000, 16'h3000, 16'h0003});
    exec(1'b0, 16'h0000);
    wait_valid("t2_valid", lat);
    check("t2_latency", 48'(lat), 48'd3);

    // Same instruction with three wait states per word
    mem_wait = 3;
    sb.push_back({16'h8000, 16'h3000, 16'h0003});
    exec(1'b1, 16'h0001);
    wait_valid("t2w_valid", lat);
    check("t2w_latency", 48'(lat), 48'd9);
    mem_wait = 0;

    // Jump: next request goes to the target one edge after exec_done
    sb.push_back({16'h0055, 16'h0000, 16'h0041});
    exec(1'b1, 16'h0040);
    @(posedge clk); #1;
    check("t3_jump_req", {o_mem_req, o_mem_addr}, {1'b1, 16'h0040});
    wait_valid("t3_valid", lat);

    // Two-word instruction at FFFF takes word 2 from 0000
    sb.push_back({16'h8001, 16'h0123, 16'h0001});
    exec(1'b1, 16'hFFFF);
    wait_valid("t5_valid", lat);

    // Decode error wins over exec_done (and the jump it carries)
    dec_err   = 1'b1;
    exec(1'b1, 16'h1234);
    dec_err   = 1'b0;
    check("t4_fault", {46'h0, o_fault, o_ir_valid}, 48'h2);
    check("t4_pc",    {32'h0, o_pc}, 48'h0001);
    any_req = 1'b0;
    repeat (10) begin
      exec_done = 1'b1;
      @(posedge clk); #1;
      any_req |= o_mem_req;
    end
    exec_done = 1'b0;
    check("t4_no_req", {46'h0, any_req, o_fault}, 48'h1);

    // Reset while word 2 is outstanding; a late ack after release is ignored
    mem[16'h0000] = 16'h8ABC;
    mem[16'h0001] = 16'h1111;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    block = 1'b1;
    check("t6_in_f2", {o_mem_req, o_mem_addr, o_ir1}, {1'b1, 16'h0001, 16'h8ABC});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst", {o_mem_req, o_pc, o_ir1}, 33'h0);
    block = 1'b0;
    @(posedge clk); #1;
    sb.push_back({16'h8ABC, 16'h1111, 16'h0002});
    rst        = 1'b0;
    late_pulse = 1'b1;
    wait_valid("t6_valid", lat);
    check("t6_latency", 48'(lat), 48'd3);

    // Memory stops answering
    block = 1'b1;
    exec(1'b0, 16'h0000);
    repeat (20) @(posedge clk);
    #1;
`ifdef FETCH_TIMEOUT_EN
    check("t6_timeout", {46'h0, o_fault, o_mem_req}, 48'h2);
`else
    check("t6_no_timeout", {o_fault, o_mem_req, o_mem_addr}, {1'b0, 1'b1, 16'h0002});
`endif

    check("sb_empty", 48'(sb.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
